sum_array_sched: RTL and testbench
==================================

# sum_array_sched

Round-robin scheduler sharing one `sum_array` accelerator core, with its ap_ctrl_hs handshake, among N_REQ requesters. Each requester raises a level request and receives a one-cycle acknowledge with the core's 32-bit `ap_return` value. The block drives the core's `ap_start`, watches `ap_ready`/`ap_done`, and flags a watchdog error if the core stalls. It sits between requesters and the core wrapper; the core's working key is out of scope here.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 32, core return width
- TIMEOUT, 1024, max cycles spent in START+WAIT before error (≥2)

Ports:
- ap_clk  in  1  single clock, all logic rising-edge
- ap_rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-requester level request, held until ack or err
- ack  out  N_REQ  one-hot one-cycle pulse: result valid for that requester
- err  out  N_REQ  one-hot one-cycle pulse: watchdog expired for that requester
- result  out  DATA_W  captured core_return; valid while ack is high
- grant_id  out  $clog2(N_REQ)  requester currently being served
- busy  out  1  high in every state except IDLE
- core_start  out  1  to core ap_start
- core_ready  in  1  core ap_ready
- core_done  in  1  core ap_done
- core_idle  in  1  core ap_idle
- core_return  in  DATA_W  core ap_return, valid with core_done

## Operation
- FSM states: IDLE, START, WAIT, RESP. All outputs registered.
- IDLE: if any req bit set and core_idle=1, pick winner by round-robin from pointer ptr (search ptr, ptr+1, ... wrapping mod N_REQ). Latch grant_id, clear watchdog counter, go START. If core_idle=0, remain in IDLE.
- START: core_start=1, held until core_ready is sampled high. On core_ready&core_done: capture core_return, go RESP. On core_ready alone: go WAIT, core_start=0 from the next cycle.
- WAIT: core_start=0. On core_done: capture core_return into result, go RESP.
- RESP: ack[grant_id]=1 for exactly one cycle; ptr <= (grant_id+1) mod N_REQ; go IDLE.
- Watchdog: counter increments on each START/WAIT cycle. When count == TIMEOUT-1 with no completion that cycle: err[grant_id]=1 for one cycle, result=0, core_start=0, ptr advances as for ack, go IDLE. A completion in the same cycle as expiry wins; it yields ack, not err.
- Requests are sampled only in IDLE. A req dropped mid-service does not abort; ack still pulses. A req still high in the IDLE cycle after its ack/err counts as a new request.
- Arithmetic: ptr wraps mod N_REQ (non-power-of-two N_REQ must wrap at N_REQ-1 → 0). Counter width is $clog2(TIMEOUT+1) and never overflows.

## Timing
- Reset values: state=IDLE, core_start=0, ack=0, err=0, result=0, grant_id=0, busy=0, ptr=0, counter=0.
- Reset mid-operation: all state returns to the values above on the next edge; no ack/err is issued for the aborted transaction. The core shares ap_rst.
- Minimum latency, for a core with ready and done in the first start cycle: req high in cycle 0 (IDLE) → core_start in cycle 1 → ack in cycle 2. IDLE is re-entered in cycle 3.
- General latency: ack appears 1 cycle after the cycle in which core_done is sampled.
- Back-to-back service: at least one IDLE cycle between transactions.

## Structure
- Package `sum_array_sched_pkg`: state enum (IDLE/START/WAIT/RESP) and default localparams for N_REQ, DATA_W, TIMEOUT.
- Sub-module `sum_array_rr_pick`: combinational round-robin picker with inputs req and ptr, outputs any and idx. It is instantiated once.
- Top: FSM, watchdog counter, result/grant registers.

## Test plan
- Single request: req=4'b0010, core completes 5 cycles after start with core_return=32'h0000_01F4 → ack=4'b0010 for one cycle, result=32'h1F4, ptr=2.
- Fairness: req=4'b1111 held continuously, each requester re-raising req after its ack → grants in order 0,1,2,3,0; no requester is served twice before the others.
- Handshake: core_ready delayed 3 cycles after core_start → core_start stays high exactly until core_ready is sampled, then drops. Also cover the ready&done-same-cycle case, which must give ack 2 cycles after req.
- Watchdog: TIMEOUT=16 and core never asserts done → err[grant_id] pulses 16 cycles after entering START, result=0, no ack. With done in the expiry cycle → ack, no err.
- Core busy: core_idle=0 with req=4'b0001 → no core_start until core_idle=1.
- Reset mid-WAIT: ap_rst asserted for 1 cycle → all outputs 0 next cycle, no ack, and the next grant begins from ptr=0.

Source files
------------

// File: rtl/sum_array_sched_pkg.sv
// Shared types and default sizing for the sum_array request scheduler.
package sum_array_sched_pkg;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/sum_array_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// starting at ptr and wrapping at N_REQ-1 back to 0.
module sum_array_rr_pick
   import sum_array_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int PTR_W = $clog2(DEF_N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic             any,
   output logic [PTR_W-1:0] idx
);

   logic [PTR_W:0] cand;

   // Walk ptr, ptr+1, ... modulo N_REQ and keep the first requester found.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(N_REQ)) begin
            cand = cand - (PTR_W+1)'(N_REQ);
         end
         if (!any && req[cand[PTR_W-1:0]]) begin
            any = 1'b1;
            idx = cand[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sum_array_sched.sv
// Round-robin scheduler sharing one sum_array core (ap_ctrl_hs) among
// N_REQ requesters, with a watchdog that aborts a stalled transaction.
module sum_array_sched
   import sum_array_sched_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst,
   input  logic [N_REQ-1:0]           req,
   output logic [N_REQ-1:0]           ack,
   output logic [N_REQ-1:0]           err,
   output logic [DATA_W-1:0]          result,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic                       core_start,
   input  logic                       core_ready,
   input  logic                       core_done,
   input  logic                       core_idle,
   input  logic [DATA_W-1:0]          core_return
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   sched_state_t      state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  grant_q, grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [N_REQ-1:0]  err_q, err_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;

   logic              pick_any;
   logic [PTR_W-1:0]  pick_idx;
   logic [PTR_W-1:0]  grant_next;
   logic [N_REQ-1:0]  grant_onehot;
   logic              expired;

   sum_array_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Helpers: wrapped successor of the current grant, its one-hot form, and watchdog expiry.
   always_comb begin
      if (grant_q == PTR_W'(N_REQ - 1)) begin
         grant_next = '0;
      end else begin
         grant_next = grant_q + PTR_W'(1);
      end
      grant_onehot          = '0;
      grant_onehot[grant_q] = 1'b1;
      expired               = (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   // Next-state and registered-output logic; a completion always beats watchdog expiry.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ack_d    = '0;
      err_d    = '0;
      start_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any && core_idle) begin
               grant_d = pick_idx;
               cnt_d   = '0;
               start_d = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (core_ready && core_done) begin
               result_d = core_return;
               ack_d    = grant_onehot;
               state_d  = RESP;
            end else if (expired) begin
               result_d = '0;
               err_d    = grant_onehot;
               ptr_d    = grant_next;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (core_ready) begin
                  state_d = WAIT;
               end else begin
                  start_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (core_done) begin
               result_d = core_return;
               ack_d    = grant_onehot;
               state_d  = RESP;
            end else if (expired) begin
               result_d = '0;
               err_d    = grant_onehot;
               ptr_d    = grant_next;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            ptr_d   = grant_next;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         ack_q    <= '0;
         err_q    <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
      end
   end

   assign ack        = ack_q;
   assign err        = err_q;
   assign result     = result_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign core_start = start_q;

endmodule

// File: tb/tb_sum_array_sched.sv
// Scoreboard bench for sum_array_sched: directed transactions push their
// expected response; a negedge monitor pops and compares on every ack/err.
module tb_sum_array_sched;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TO = 16;

   typedef struct {
      bit             is_err;
      logic [N-1:0]   vec;
      logic [DW-1:0]  res;
   } exp_t;

   logic          ap_clk = 1'b0;
   logic          ap_rst;
   logic [N-1:0]  req;
   logic [N-1:0]  ack;
   logic [N-1:0]  err;
   logic [DW-1:0] result;
   logic [1:0]    grant_id;
   logic          busy;
   logic          core_start;
   logic          core_ready;
   logic          core_done;
   logic          core_idle;
   logic [DW-1:0] core_return;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t exp_q[$];

   sum_array_sched #(
      .N_REQ   (N),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .req         (req),
      .ack         (ack),
      .err         (err),
      .result      (result),
      .grant_id    (grant_id),
      .busy        (busy),
      .core_start  (core_start),
      .core_ready  (core_ready),
      .core_done   (core_done),
      .core_idle   (core_idle),
      .core_return (core_return)
   );

   // Free-running clock.
   always #5 ap_clk = ~ap_clk;

   // Cycle counter used to measure latencies.
   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] r);
      req = r;
   endtask

   task automatic pushExp(input bit is_err, input logic [N-1:0] vec, input logic [DW-1:0] res);
      exp_t e;
      e.is_err = is_err;
      e.vec    = vec;
      e.res    = res;
      exp_q.push_back(e);
   endtask

   // Behavioral core: waits for core_start, raises ready after ready_lat
   // cycles, and done done_lat cycles after ready (same cycle when 0).
   task automatic serveCore(input int ready_lat, input int done_lat, input logic [DW-1:0] ret,
                            input bit never_done, output int start_cyc);
      int t;
      t = 0;
      while (core_start !== 1'b1 && t < 40) begin
         @(negedge ap_clk);
         t++;
      end
      checkOutput("core_start_seen", core_start, 1);
      start_cyc = cyc;
      for (int c = 0; c < ready_lat; c++) begin
         checkOutput("start_held", core_start, 1);
         @(negedge ap_clk);
      end
      checkOutput("start_at_ready", core_start, 1);
      core_ready = 1'b1;
      if (!never_done && done_lat == 0) begin
         core_done   = 1'b1;
         core_return = ret;
      end
      @(negedge ap_clk);
      core_ready  = 1'b0;
      core_done   = 1'b0;
      core_return = '0;
      checkOutput("start_dropped", core_start, 0);
      if (!never_done && done_lat > 0) begin
         repeat (done_lat - 1) @(negedge ap_clk);
         core_done   = 1'b1;
         core_return = ret;
         @(negedge ap_clk);
         core_done   = 1'b0;
         core_return = '0;
      end
   endtask

   task automatic waitResponse(output int resp_cyc);
      int t;
      t = 0;
      while ((ack | err) == '0 && t < 60) begin
         @(negedge ap_clk);
         t++;
      end
      if ((ack | err) == '0) begin
         checks++;
         failures++;
         $display("[TB] FAIL resp_timeout actual=none required=ack_or_err");
      end
      resp_cyc = cyc;
   endtask

   task automatic finishTxn();
      applyStimulus('0);
      @(negedge ap_clk);
   endtask

   // Scoreboard monitor: every ack/err pulse must match the oldest expectation.
   always @(negedge ap_clk) begin : monitor
      exp_t e;
      if ((ack | err) != '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_response actual ack=%b err=%b required none", ack, err);
         end else begin
            e = exp_q.pop_front();
            checkOutput("sb_ack", 32'(ack), e.is_err ? 32'd0 : 32'(e.vec));
            checkOutput("sb_err", 32'(err), e.is_err ? 32'(e.vec) : 32'd0);
            checkOutput("sb_result", result, e.res);
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Directed stimulus sequence.
   initial begin
      int s_cyc, r_cyc, t0;
      ap_rst      = 1'b1;
      req         = '0;
      core_ready  = 1'b0;
      core_done   = 1'b0;
      core_idle   = 1'b1;
      core_return = '0;
      repeat (2) @(negedge ap_clk);
      checkOutput("rst_ack", 32'(ack), 0);
      checkOutput("rst_err", 32'(err), 0);
      checkOutput("rst_result", result, 0);
      checkOutput("rst_grant_id", 32'(grant_id), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_core_start", 32'(core_start), 0);
      ap_rst = 1'b0;
      @(negedge ap_clk);

      // Single request from requester 1, done 5 cycles after start; ptr -> 2.
      pushExp(1'b0, 4'b0010, 32'h0000_01F4);
      applyStimulus(4'b0010);
      serveCore(0, 5, 32'h0000_01F4, 1'b0, s_cyc);
      waitResponse(r_cyc);
      checkOutput("t1_latency", 32'(r_cyc - s_cyc), 6);
      checkOutput("t1_grant_id", 32'(grant_id), 1);
      checkOutput("t1_busy_resp", 32'(busy), 1);
      finishTxn();

      // ptr=2 with req 0101 picks 2; then ptr=3 wraps to pick 0.
      pushExp(1'b0, 4'b0100, 32'hA5A5_0002);
      applyStimulus(4'b0101);
      serveCore(0, 1, 32'hA5A5_0002, 1'b0, s_cyc);
      waitResponse(r_cyc);
      finishTxn();
      pushExp(1'b0, 4'b0001, 32'h0000_0003);
      applyStimulus(4'b0101);
      serveCore(1, 1, 32'h0000_0003, 1'b0, s_cyc);
      waitResponse(r_cyc);
      finishTxn();

      // Minimum latency: ready and done in the first start cycle (ptr=1 picks 3).
      t0 = cyc;
      pushExp(1'b0, 4'b1000, 32'hDEAD_BEEF);
      applyStimulus(4'b1000);
      @(negedge ap_clk);
      serveCore(0, 0, 32'hDEAD_BEEF, 1'b0, s_cyc);
      waitResponse(r_cyc);
      checkOutput("t4_start_latency", 32'(s_cyc - t0), 1);
      checkOutput("t4_ack_latency", 32'(r_cyc - t0), 2);
      finishTxn();
      checkOutput("t4_idle_after", 32'(busy), 0);

      // Handshake: ready 3 cycles after start, done 2 cycles later (ptr=0 picks 1).
      pushExp(1'b0, 4'b0010, 32'h1234_5678);
      applyStimulus(4'b0010);
      serveCore(3, 2, 32'h1234_5678, 1'b0, s_cyc);
      waitResponse(r_cyc);
      checkOutput("t5_latency", 32'(r_cyc - s_cyc), 6);
      finishTxn();

      // Watchdog: core never completes (ptr=2 wraps to 0); err 16 cycles after start.
      pushExp(1'b1, 4'b0001, 32'h0);
      applyStimulus(4'b0001);
      serveCore(0, 0, 32'h0, 1'b1, s_cyc);
      waitResponse(r_cyc);
      checkOutput("t6_err_latency", 32'(r_cyc - s_cyc), 16);
      checkOutput("t6_busy_at_err", 32'(busy), 0);
      finishTxn();

      // Done in the expiry cycle wins: ack, no err (ptr=1 picks 2).
      pushExp(1'b0, 4'b0100, 32'h0000_0F0F);
      applyStimulus(4'b0100);
      serveCore(0, 15, 32'h0000_0F0F, 1'b0, s_cyc);
      waitResponse(r_cyc);
      checkOutput("t7_latency", 32'(r_cyc - s_cyc), 16);
      finishTxn();

      // Core busy: no start while core_idle=0 (ptr=3 wraps to 0).
      core_idle = 1'b0;
      applyStimulus(4'b0001);
      repeat (4) begin
         @(negedge ap_clk);
         checkOutput("t8_no_start", 32'(core_start), 0);
      end
      checkOutput("t8_not_busy", 32'(busy), 0);
      core_idle = 1'b1;
      t0 = cyc;
      pushExp(1'b0, 4'b0001, 32'h0000_0077);
      @(negedge ap_clk);
      serveCore(0, 0, 32'h0000_0077, 1'b0, s_cyc);
      waitResponse(r_cyc);
      checkOutput("t8_start_after_idle", 32'(s_cyc - t0), 1);
      finishTxn();

      // Reset mid-WAIT (ptr=1 picks 2): everything clears, no response issued.
      applyStimulus(4'b0100);
      serveCore(0, 0, 32'h0, 1'b1, s_cyc);
      checkOutput("t9_busy_in_wait", 32'(busy), 1);
      checkOutput("t9_grant_in_wait", 32'(grant_id), 2);
      ap_rst = 1'b1;
      applyStimulus('0);
      @(negedge ap_clk);
      checkOutput("t9_ack", 32'(ack), 0);
      checkOutput("t9_err", 32'(err), 0);
      checkOutput("t9_result", result, 0);
      checkOutput("t9_grant_id", 32'(grant_id), 0);
      checkOutput("t9_busy", 32'(busy), 0);
      checkOutput("t9_core_start", 32'(core_start), 0);
      ap_rst = 1'b0;
      repeat (3) @(negedge ap_clk);

      // Fairness from ptr=0 with all requests held: 0,1,2,3,0.
      applyStimulus(4'b1111);
      for (int k = 0; k < 5; k++) begin
         pushExp(1'b0, 4'(1 << (k % 4)), 32'h0000_0100 + 32'(k));
         serveCore(0, 1, 32'h0000_0100 + 32'(k), 1'b0, s_cyc);
         waitResponse(r_cyc);
         checkOutput("t10_grant_id", 32'(grant_id), 32'(k % 4));
      end
      finishTxn();

      repeat (5) @(negedge ap_clk);
      checkOutput("sb_queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
